// File: rtl/temp_window_averager.sv
// rtl/temp_window_averager.sv - moving average over the last 2^LOG2_DEPTH temperature samples
module temp_window_averager #(
  parameter int LOG2_DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] sample_in,
  input  logic        clear,
  output logic [15:0] temp_average,
  output logic        avg_valid,
  output logic        window_full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = 16 + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(DEPTH);

  logic [15:0]         win_buf_q [DEPTH];
  logic [15:0]         win_buf_d [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0]   fill_q, fill_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [15:0]           avg_q, avg_d;
  logic                  avg_valid_q, avg_valid_d;
  logic                  full_q, full_d;

  logic [15:0]           oldest;
  logic [SW-1:0]         new_sum;
  logic [LOG2_DEPTH:0]   fill_inc;

  // The slot about to be overwritten holds the sample leaving the window.
  // The sum always contains that sample, so the subtraction never wraps.
  assign oldest   = win_buf_q[wr_ptr_q];
  assign new_sum  = sum_q + SW'(sample_in) - SW'(oldest);
  assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + (LOG2_DEPTH + 1)'(1);

  // Next-state: clear flushes everything, an accepted sample updates window and average.
  always_comb begin
    win_buf_d   = win_buf_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    sum_d       = sum_q;
    avg_d       = avg_q;
    full_d      = full_q;
    avg_valid_d = 1'b0;
    if (clear) begin
      win_buf_d = '{default: '0};
      wr_ptr_d  = '0;
      fill_d    = '0;
      sum_d     = '0;
      avg_d     = '0;
      full_d    = 1'b0;
    end else if (sample_valid) begin
      win_buf_d[wr_ptr_q] = sample_in;
      wr_ptr_d            = wr_ptr_q + LOG2_DEPTH'(1);
      fill_d              = fill_inc;
      sum_d               = new_sum;
      // Empty slots read as zero, so the divisor is always DEPTH.
      avg_d               = new_sum[SW-1:LOG2_DEPTH];
      full_d              = (fill_inc == FILL_MAX);
      avg_valid_d         = (fill_inc == FILL_MAX);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_buf_q   <= '{default: '0};
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      win_buf_q   <= win_buf_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      sum_q       <= sum_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      full_q      <= full_d;
    end
  end

  assign temp_average = avg_q;
  assign avg_valid    = avg_valid_q;
  assign window_full  = full_q;

endmodule

// File: tb/tb_temp_window_averager.sv
// tb/tb_temp_window_averager.sv - directed self-checking bench for temp_window_averager
module tb_temp_window_averager;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic        clear;
  logic [15:0] temp_average;
  logic        avg_valid;
  logic        window_full;

  int n_checks;
  int n_fail;

  temp_window_averager #(.LOG2_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .clear        (clear),
    .temp_average (temp_average),
    .avg_valid    (avg_valid),
    .window_full  (window_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    clear = 1'b0;
    #12;
    n_checks++;
    if (temp_average !== 16'd0) begin
      n_fail++; $display("FAIL reset_avg: got %0d expected 0", temp_average);
    end
    n_checks++;
    if (avg_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", avg_valid);
    end
    n_checks++;
    if (window_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_full: got %b expected 0", window_full);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fill();
    logic [15:0] smp [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
    logic [15:0] exp [4] = '{16'd25, 16'd75, 16'd150, 16'd250};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in = smp[i];
      @(posedge clk); #1;
      n_checks++;
      if (temp_average !== exp[i] || avg_valid !== (i == 3) || window_full !== (i == 3)) begin
        n_fail++;
        $display("FAIL fill_%0d: got avg=%0d v=%b f=%b expected avg=%0d v=%b f=%b",
                 i, temp_average, avg_valid, window_full, exp[i], (i == 3), (i == 3));
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] smp [2] = '{16'd500, 16'd0};
    logic [15:0] exp [2] = '{16'd350, 16'd300};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in = smp[i];
      @(posedge clk); #1;
      n_checks++;
      if (temp_average !== exp[i] || avg_valid !== 1'b1 || window_full !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_%0d: got avg=%0d v=%b f=%b expected avg=%0d v=1 f=1",
                 i, temp_average, avg_valid, window_full, exp[i]);
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (avg_valid !== 1'b0 || temp_average !== 16'd300) begin
      n_fail++;
      $display("FAIL wrap_idle: got avg=%0d v=%b expected avg=300 v=0", temp_average, avg_valid);
    end
  endtask

  task automatic test_truncation();
    logic [15:0] smp [8] = '{16'd1, 16'd1, 16'd1, 16'd2,
                             16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic [15:0] exp [8] = '{16'd0, 16'd0, 16'd0, 16'd1,
                             16'h4000, 16'h8000, 16'hBFFF, 16'hFFFF};
    do_clear();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in = smp[i];
      @(posedge clk); #1;
      n_checks++;
      if (temp_average !== exp[i] || avg_valid !== (i >= 3)) begin
        n_fail++;
        $display("FAIL trunc_%0d: got avg=%0h v=%b expected avg=%0h v=%b",
                 i, temp_average, avg_valid, exp[i], (i >= 3));
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic test_gapped();
    logic [15:0] smp [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
    logic [15:0] exp [4] = '{16'd25, 16'd75, 16'd150, 16'd250};
    do_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in = smp[i];
      @(posedge clk); #1;
      n_checks++;
      if (temp_average !== exp[i] || avg_valid !== (i == 3) || window_full !== (i == 3)) begin
        n_fail++;
        $display("FAIL gap_%0d: got avg=%0d v=%b f=%b expected avg=%0d v=%b f=%b",
                 i, temp_average, avg_valid, window_full, exp[i], (i == 3), (i == 3));
      end
      @(negedge clk);
      sample_valid = 1'b0;
      sample_in = 16'hAAAA;
      for (int g = 0; g < 5; g++) begin
        @(posedge clk); #1;
        n_checks++;
        if (temp_average !== exp[i] || avg_valid !== 1'b0 || window_full !== (i == 3)) begin
          n_fail++;
          $display("FAIL gap_idle_%0d_%0d: got avg=%0d v=%b f=%b expected avg=%0d v=0 f=%b",
                   i, g, temp_average, avg_valid, window_full, exp[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_clear_priority();
    @(negedge clk);
    clear = 1'b1;
    sample_valid = 1'b1;
    sample_in = 16'd900;
    @(posedge clk); #1;
    n_checks++;
    if (temp_average !== 16'd0 || window_full !== 1'b0 || avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_prio: got avg=%0d v=%b f=%b expected avg=0 v=0 f=0",
               temp_average, avg_valid, window_full);
    end
    @(negedge clk);
    clear = 1'b0;
    sample_in = 16'd40;
    @(posedge clk); #1;
    n_checks++;
    if (temp_average !== 16'd10 || window_full !== 1'b0 || avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_drop: got avg=%0d v=%b f=%b expected avg=10 v=0 f=0",
               temp_average, avg_valid, window_full);
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [15:0] exp [4] = '{16'd10, 16'd20, 16'd30, 16'd40};
    do_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in = 16'(100 * (i + 1));
    end
    @(negedge clk);
    sample_valid = 1'b0;
    n_checks++;
    if (window_full !== 1'b1 || temp_average !== 16'd250) begin
      n_fail++;
      $display("FAIL arst_pre: got avg=%0d f=%b expected avg=250 f=1", temp_average, window_full);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (temp_average !== 16'd0 || window_full !== 1'b0 || avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_async: got avg=%0d v=%b f=%b expected avg=0 v=0 f=0",
               temp_average, avg_valid, window_full);
    end
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in = 16'd40;
      @(posedge clk); #1;
      n_checks++;
      if (temp_average !== exp[i] || avg_valid !== (i == 3) || window_full !== (i == 3)) begin
        n_fail++;
        $display("FAIL arst_refill_%0d: got avg=%0d v=%b f=%b expected avg=%0d v=%b f=%b",
                 i, temp_average, avg_valid, window_full, exp[i], (i == 3), (i == 3));
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_fill();
    test_wrap();
    test_truncation();
    test_gapped();
    test_clear_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
